// File: rtl/ofs_plat_ccip_mmio_rd_watchdog_pkg.sv
// ----------------------------------------------------------------------------
// ofs_plat_ccip_mmio_rd_watchdog_pkg
//
// Purpose: shared CCI-P MMIO types for the MMIO read watchdog and its tid
//          FIFO. The MMIO tid and data widths are defined once here and
//          imported by every file of the block.
//
// Contents:
//   CCIP_MMIO_TID_WIDTH   - MMIO transaction id width (9)
//   CCIP_MMIO_DATA_WIDTH  - MMIO read data width (64)
//   t_ccip_mmio_tid       - MMIO tid type
//   t_ccip_mmio_data      - MMIO read data type
//   t_wd_state            - watchdog FSM state encoding
// ----------------------------------------------------------------------------
package ofs_plat_ccip_mmio_rd_watchdog_pkg;

  localparam int CCIP_MMIO_TID_WIDTH  = 9;
  localparam int CCIP_MMIO_DATA_WIDTH = 64;

  typedef logic [CCIP_MMIO_TID_WIDTH-1:0]  t_ccip_mmio_tid;
  typedef logic [CCIP_MMIO_DATA_WIDTH-1:0] t_ccip_mmio_data;

  typedef enum logic {
    WD_EMPTY = 1'b0,
    WD_WAIT  = 1'b1
  } t_wd_state;

endpackage

// File: rtl/ofs_plat_ccip_mmio_tid_fifo.sv
// ----------------------------------------------------------------------------
// ofs_plat_ccip_mmio_tid_fifo
//
// Purpose: in-order FIFO of outstanding MMIO read tids. The head entry is
//          visible combinationally so the watchdog can compare it against
//          AFU responses in the same cycle.
//
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   push_i        - write push_tid_i (dropped when full unless popping too)
//   push_tid_i    - tid to enqueue
//   pop_i         - remove the head entry (ignored when empty)
//   head_o        - tid at the head of the FIFO
//   full_o        - DEPTH entries held
//   empty_o       - no entries held
//   count_o       - number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module ofs_plat_ccip_mmio_tid_fifo
  import ofs_plat_ccip_mmio_rd_watchdog_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  t_ccip_mmio_tid         push_tid_i,
  input  logic                   pop_i,
  output t_ccip_mmio_tid         head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  t_ccip_mmio_tid mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  // Pointers carry one extra bit so that equal low bits distinguish
  // full (MSBs differ) from empty (MSBs equal).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO still fits when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; validity is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_tid_i;
    end
  end

endmodule

// File: rtl/ofs_plat_ccip_mmio_rd_watchdog.sv
// ----------------------------------------------------------------------------
// ofs_plat_ccip_mmio_rd_watchdog
//
// Purpose: tracks host MMIO reads in arrival order and guarantees every read
//          gets exactly one response. AFU responses matching the oldest
//          outstanding tid are forwarded; if the AFU stays silent for
//          TIMEOUT_CYCLES on the oldest read, a synthetic response carrying
//          TIMEOUT_DATA is generated instead.
//
// Ports:
//   clk, reset_n                     - clock, synchronous active-low reset
//   fiu_rd_valid / fiu_rd_tid        - MMIO read request from host
//   afu_rsp_valid / _tid / _data     - MMIO read response from AFU
//   fiu_rsp_valid / _tid / _data     - registered response toward host
//   outstanding                      - reads currently tracked
//   err_timeout                      - sticky: a read timed out
//   err_overflow                     - sticky: a read was dropped (FIFO full)
//   err_stray                        - sticky: an AFU response was dropped
// ----------------------------------------------------------------------------
module ofs_plat_ccip_mmio_rd_watchdog
  import ofs_plat_ccip_mmio_rd_watchdog_pkg::*;
#(
  parameter int              DEPTH          = 64,
  parameter int              TIMEOUT_CYCLES = 512,
  parameter t_ccip_mmio_data TIMEOUT_DATA   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fiu_rd_valid,
  input  t_ccip_mmio_tid         fiu_rd_tid,
  input  logic                   afu_rsp_valid,
  input  t_ccip_mmio_tid         afu_rsp_tid,
  input  t_ccip_mmio_data        afu_rsp_data,
  output logic                   fiu_rsp_valid,
  output t_ccip_mmio_tid         fiu_rsp_tid,
  output t_ccip_mmio_data        fiu_rsp_data,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_timeout,
  output logic                   err_overflow,
  output logic                   err_stray
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              TW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
  localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1);

  t_wd_state       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            rsp_valid_q;
  t_ccip_mmio_tid  rsp_tid_q;
  t_ccip_mmio_data rsp_data_q;
  logic            err_timeout_q, err_overflow_q, err_stray_q;

  t_ccip_mmio_tid  head_tid;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;

  logic            head_vld, afu_match, afu_stray, expire, pop, push_ok, overflow;

  ofs_plat_ccip_mmio_tid_fifo #(
    .DEPTH (DEPTH)
  ) u_tid_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (fiu_rd_valid),
    .push_tid_i (fiu_rd_tid),
    .pop_i      (pop),
    .head_o     (head_tid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Pop decision: a matching AFU response always beats a same-cycle expiry.
  always_comb begin
    head_vld  = (state_q == WD_WAIT);
    afu_match = afu_rsp_valid && head_vld && (afu_rsp_tid == head_tid);
    afu_stray = afu_rsp_valid && !afu_match;
    expire    = head_vld && (timer_q == TIMER_LAST) && !afu_match;
    pop       = afu_match || expire;
    push_ok   = fiu_rd_valid && (!fifo_full || pop);
    overflow  = fiu_rd_valid && !push_ok;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WD_EMPTY: if (push_ok) state_d = WD_WAIT;
      WD_WAIT:  if (pop && !push_ok && (fifo_count == CNT_ONE)) state_d = WD_EMPTY;
      default:  state_d = WD_EMPTY;
    endcase
  end

  // Head timer restarts whenever a new tid becomes head and saturates at the
  // expiry value, so it cannot wrap even if the pop were somehow suppressed.
  always_comb begin
    timer_d = timer_q;
    if (!head_vld || pop) begin
      timer_d = '0;
    end else if (timer_q != TIMER_LAST) begin
      timer_d = timer_q + TIMER_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= WD_EMPTY;
      timer_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_tid_q      <= '0;
      rsp_data_q     <= '0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      err_stray_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      rsp_valid_q    <= pop;
      if (pop) begin
        rsp_tid_q    <= head_tid;
        rsp_data_q   <= afu_match ? afu_rsp_data : TIMEOUT_DATA;
      end
      err_timeout_q  <= err_timeout_q  | expire;
      err_overflow_q <= err_overflow_q | overflow;
      err_stray_q    <= err_stray_q    | afu_stray;
    end
  end

  assign fiu_rsp_valid = rsp_valid_q;
  assign fiu_rsp_tid   = rsp_tid_q;
  assign fiu_rsp_data  = rsp_data_q;
  assign outstanding   = fifo_count;
  assign err_timeout   = err_timeout_q;
  assign err_overflow  = err_overflow_q;
  assign err_stray     = err_stray_q;

`ifndef SYNTHESIS
  // Simulation-only sanity checks, armed once reset has been seen.
  logic rst_seen_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_seen_q <= 1'b1;
    end
    if (rst_seen_q && reset_n) begin
      assert (!$isunknown(fiu_rsp_valid));
      assert (head_vld == !fifo_empty);
    end
  end
`endif

endmodule

// File: tb/tb_ofs_plat_ccip_mmio_rd_watchdog.sv
module tb_ofs_plat_ccip_mmio_rd_watchdog;
  import ofs_plat_ccip_mmio_rd_watchdog_pkg::*;

  localparam int          DEPTH = 64;
  localparam int          TMO   = 512;
  localparam logic [63:0] TDATA = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            fiu_rd_valid;
  t_ccip_mmio_tid  fiu_rd_tid;
  logic            afu_rsp_valid;
  t_ccip_mmio_tid  afu_rsp_tid;
  t_ccip_mmio_data afu_rsp_data;
  logic            fiu_rsp_valid;
  t_ccip_mmio_tid  fiu_rsp_tid;
  t_ccip_mmio_data fiu_rsp_data;
  logic [6:0]      outstanding;
  logic            err_timeout, err_overflow, err_stray;

  typedef logic [72:0] sb_t;
  sb_t sb[$];
  sb_t want;
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  ofs_plat_ccip_mmio_rd_watchdog #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_DATA   (TDATA)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fiu_rd_valid  (fiu_rd_valid),
    .fiu_rd_tid    (fiu_rd_tid),
    .afu_rsp_valid (afu_rsp_valid),
    .afu_rsp_tid   (afu_rsp_tid),
    .afu_rsp_data  (afu_rsp_data),
    .fiu_rsp_valid (fiu_rsp_valid),
    .fiu_rsp_tid   (fiu_rsp_tid),
    .fiu_rsp_data  (fiu_rsp_data),
    .outstanding   (outstanding),
    .err_timeout   (err_timeout),
    .err_overflow  (err_overflow),
    .err_stray     (err_stray)
  );

  // Inputs change just after a negedge; outputs are read at negedges.
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    fiu_rd_valid = 1'b0; fiu_rd_tid = '0;
    afu_rsp_valid = 1'b0; afu_rsp_tid = '0; afu_rsp_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    checks++;
    if (outstanding !== 7'd0) begin
      failures++; $display("FAIL reset_outstanding got=%0d want=0", outstanding);
    end
    checks++;
    if ({fiu_rsp_valid, fiu_rsp_tid, fiu_rsp_data} !== 74'd0) begin
      failures++; $display("FAIL reset_rsp got v=%b tid=%h data=%h want all 0",
                           fiu_rsp_valid, fiu_rsp_tid, fiu_rsp_data);
    end
    checks++;
    if ({err_timeout, err_overflow, err_stray} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", {err_timeout, err_overflow, err_stray});
    end
  endtask

  task automatic test_basic();
    apply_reset();
    fiu_rd_valid = 1'b1; fiu_rd_tid = 9'h005;
    @(negedge clk);
    fiu_rd_valid = 1'b0;
    repeat (9) @(negedge clk);
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h005; afu_rsp_data = 64'h1234;
    sb.push_back({9'h005, 64'h1234});
    @(negedge clk);
    afu_rsp_valid = 1'b0;
    checks++;
    if (fiu_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL basic_latency got valid=%b want=1", fiu_rsp_valid);
    end
    if (fiu_rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL basic_unexpected got tid=%h data=%h want none", fiu_rsp_tid, fiu_rsp_data);
      end else begin
        want = sb.pop_front();
        if ({fiu_rsp_tid, fiu_rsp_data} !== want) begin
          failures++; $display("FAIL basic_rsp got=%h want=%h", {fiu_rsp_tid, fiu_rsp_data}, want);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (fiu_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL basic_single got valid=%b want=0", fiu_rsp_valid);
    end
    checks++;
    if ({err_timeout, err_overflow, err_stray, outstanding} !== 10'd0) begin
      failures++; $display("FAIL basic_state got flags=%b out=%0d want 000/0",
                           {err_timeout, err_overflow, err_stray}, outstanding);
    end
  endtask

  task automatic test_timeout();
    int first = -1;
    apply_reset();
    fiu_rd_valid = 1'b1; fiu_rd_tid = 9'h011;
    sb.push_back({9'h011, TDATA});
    for (int k = 1; k <= TMO + 4; k++) begin
      @(negedge clk);
      fiu_rd_valid = 1'b0;
      if (fiu_rsp_valid) begin
        if (first < 0) first = k;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL timeout_unexpected got tid=%h data=%h want none", fiu_rsp_tid, fiu_rsp_data);
        end else begin
          want = sb.pop_front();
          if ({fiu_rsp_tid, fiu_rsp_data} !== want) begin
            failures++; $display("FAIL timeout_rsp got=%h want=%h", {fiu_rsp_tid, fiu_rsp_data}, want);
          end
        end
      end
    end
    checks++;
    if (first != TMO + 1) begin
      failures++; $display("FAIL timeout_latency got=%0d want=%0d", first, TMO + 1);
    end
    checks++;
    if ({err_timeout, err_overflow, err_stray} !== 3'b100 || outstanding !== 7'd0) begin
      failures++; $display("FAIL timeout_flags got flags=%b out=%0d want 100/0",
                           {err_timeout, err_overflow, err_stray}, outstanding);
    end
  endtask

  task automatic test_overflow();
    int nrsp = 0;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      fiu_rd_valid = 1'b1; fiu_rd_tid = 9'(i);
      @(negedge clk);
    end
    checks++;
    if (outstanding !== 7'd64 || err_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_full got out=%0d ovf=%b want 64/0", outstanding, err_overflow);
    end
    fiu_rd_tid = 9'd64;
    @(negedge clk);
    fiu_rd_valid = 1'b0;
    checks++;
    if (outstanding !== 7'd64 || err_overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_drop got out=%0d ovf=%b want 64/1", outstanding, err_overflow);
    end
    // Drain in order; the first pop coincides with a push at full.
    for (int i = 0; i <= DEPTH; i++) begin
      afu_rsp_valid = 1'b1;
      afu_rsp_tid   = (i == DEPTH) ? 9'h100 : 9'(i);
      afu_rsp_data  = 64'hA5A5_0000_0000_0000 | 64'(i);
      sb.push_back({afu_rsp_tid, afu_rsp_data});
      if (i == 0) begin
        fiu_rd_valid = 1'b1; fiu_rd_tid = 9'h100;
      end
      @(negedge clk);
      fiu_rd_valid = 1'b0;
      if (i == 0) begin
        checks++;
        if (outstanding !== 7'd64) begin
          failures++; $display("FAIL full_push_pop got out=%0d want 64", outstanding);
        end
      end
      if (fiu_rsp_valid) begin
        nrsp++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL ovf_unexpected got tid=%h data=%h want none", fiu_rsp_tid, fiu_rsp_data);
        end else begin
          want = sb.pop_front();
          if ({fiu_rsp_tid, fiu_rsp_data} !== want) begin
            failures++; $display("FAIL ovf_rsp got=%h want=%h", {fiu_rsp_tid, fiu_rsp_data}, want);
          end
        end
      end
    end
    afu_rsp_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fiu_rsp_valid) begin
        nrsp++;
        checks++;
        failures++; $display("FAIL ovf_extra got tid=%h data=%h want none", fiu_rsp_tid, fiu_rsp_data);
      end
    end
    checks++;
    if (nrsp != DEPTH + 1 || sb.size() != 0) begin
      failures++; $display("FAIL ovf_count got rsp=%0d left=%0d want %0d/0", nrsp, sb.size(), DEPTH + 1);
    end
    checks++;
    if ({err_timeout, err_overflow, err_stray} !== 3'b010 || outstanding !== 7'd0) begin
      failures++; $display("FAIL ovf_flags got flags=%b out=%0d want 010/0",
                           {err_timeout, err_overflow, err_stray}, outstanding);
    end
  endtask

  task automatic test_stray();
    apply_reset();
    fiu_rd_valid = 1'b1; fiu_rd_tid = 9'h003;
    @(negedge clk);
    fiu_rd_valid = 1'b0;
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h007; afu_rsp_data = 64'hBAD;
    @(negedge clk);
    afu_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fiu_rsp_valid !== 1'b0 || err_stray !== 1'b1 || outstanding !== 7'd1) begin
      failures++; $display("FAIL stray_drop got v=%b stray=%b out=%0d want 0/1/1",
                           fiu_rsp_valid, err_stray, outstanding);
    end
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h003; afu_rsp_data = 64'h3333;
    sb.push_back({9'h003, 64'h3333});
    @(negedge clk);
    afu_rsp_valid = 1'b0;
    checks++;
    if (fiu_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL stray_head got valid=%b want=1", fiu_rsp_valid);
    end
    if (fiu_rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL stray_unexpected got tid=%h data=%h want none", fiu_rsp_tid, fiu_rsp_data);
      end else begin
        want = sb.pop_front();
        if ({fiu_rsp_tid, fiu_rsp_data} !== want) begin
          failures++; $display("FAIL stray_rsp got=%h want=%h", {fiu_rsp_tid, fiu_rsp_data}, want);
        end
      end
    end
    // Response while nothing is outstanding.
    apply_reset();
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h000; afu_rsp_data = 64'h1;
    @(negedge clk);
    afu_rsp_valid = 1'b0;
    checks++;
    if (fiu_rsp_valid !== 1'b0 || err_stray !== 1'b1) begin
      failures++; $display("FAIL stray_empty got v=%b stray=%b want 0/1", fiu_rsp_valid, err_stray);
    end
  endtask

  task automatic test_race();
    int first = -1;
    apply_reset();
    fiu_rd_valid = 1'b1; fiu_rd_tid = 9'h022;
    for (int k = 1; k <= TMO + 3; k++) begin
      @(negedge clk);
      fiu_rd_valid = 1'b0;
      if (fiu_rsp_valid) begin
        if (first < 0) first = k;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL race_unexpected got tid=%h data=%h want none", fiu_rsp_tid, fiu_rsp_data);
        end else begin
          want = sb.pop_front();
          if ({fiu_rsp_tid, fiu_rsp_data} !== want) begin
            failures++; $display("FAIL race_rsp got=%h want=%h", {fiu_rsp_tid, fiu_rsp_data}, want);
          end
        end
      end
      if (k == TMO) begin
        afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h022; afu_rsp_data = 64'h5555;
        sb.push_back({9'h022, 64'h5555});
      end else begin
        afu_rsp_valid = 1'b0;
      end
    end
    checks++;
    if (first != TMO + 1 || sb.size() != 0) begin
      failures++; $display("FAIL race_latency got=%0d left=%0d want %0d/0", first, sb.size(), TMO + 1);
    end
    checks++;
    if ({err_timeout, err_overflow, err_stray} !== 3'b000) begin
      failures++; $display("FAIL race_flags got=%b want=000", {err_timeout, err_overflow, err_stray});
    end
  endtask

  task automatic test_reset_mid();
    int nrsp = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      fiu_rd_valid = 1'b1; fiu_rd_tid = 9'h040 + 9'(i);
      @(negedge clk);
    end
    fiu_rd_valid = 1'b0;
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h1FF; afu_rsp_data = 64'h0;
    @(negedge clk);
    afu_rsp_valid = 1'b0;
    checks++;
    if (outstanding !== 7'd5 || err_stray !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got out=%0d stray=%b want 5/1", outstanding, err_stray);
    end
    // Inputs active during reset must be ignored.
    reset_n = 1'b0;
    fiu_rd_valid = 1'b1; fiu_rd_tid = 9'h077;
    afu_rsp_valid = 1'b1; afu_rsp_tid = 9'h040; afu_rsp_data = 64'hDEAD;
    @(negedge clk);
    reset_n = 1'b1;
    fiu_rd_valid = 1'b0; afu_rsp_valid = 1'b0;
    checks++;
    if (outstanding !== 7'd0 || fiu_rsp_valid !== 1'b0 ||
        {err_timeout, err_overflow, err_stray} !== 3'b000) begin
      failures++; $display("FAIL rstmid_clear got out=%0d v=%b flags=%b want 0/0/000",
                           outstanding, fiu_rsp_valid, {err_timeout, err_overflow, err_stray});
    end
    repeat (TMO + 50) begin
      @(negedge clk);
      if (fiu_rsp_valid) nrsp++;
    end
    checks++;
    if (nrsp != 0 || outstanding !== 7'd0 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL rstmid_quiet got rsp=%0d out=%0d tmo=%b want 0/0/0",
                           nrsp, outstanding, err_timeout);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    fiu_rd_valid = 1'b0; fiu_rd_tid = '0;
    afu_rsp_valid = 1'b0; afu_rsp_tid = '0; afu_rsp_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_stray();
    test_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ofs_plat_ccip_mmio_rd_watchdog.md
OFS_PLAT_CCIP_MMIO_RD_WATCHDOG -- requirements
Module: ofs_plat_ccip_mmio_rd_watchdog

Interface
REQ-001 SHALL have parameter DEPTH, default 64, max outstanding MMIO reads tracked (power of 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 512, cycles a head read may wait before synthetic response.
REQ-003 SHALL have parameter TIMEOUT_DATA, default 64'hFFFF_FFFF_FFFF_FFFF, data returned on timeout.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 fiu_rd_valid  in  1  MMIO read request from host (sRx.c0.mmioRdValid).
REQ-007 fiu_rd_tid  in  9  tid of MMIO read request.
REQ-008 afu_rsp_valid  in  1  AFU MMIO read response (AFU sTx.c2.mmioRdValid).
REQ-009 afu_rsp_tid  in  9  tid of AFU response.
REQ-010 afu_rsp_data  in  64  AFU response data.
REQ-011 fiu_rsp_valid  out  1  response toward host (sTx.c2.mmioRdValid).
REQ-012 fiu_rsp_tid  out  9  response tid.
REQ-013 fiu_rsp_data  out  64  response data.
REQ-014 outstanding  out  $clog2(DEPTH)+1  reads currently tracked.
REQ-015 err_timeout / err_overflow / err_stray  out  1 each  sticky error flags.

Function
REQ-016 Each fiu_rd_valid cycle SHALL push fiu_rd_tid into an in-order tid FIFO; no backpressure exists.
REQ-017 Push when FIFO full (outstanding==DEPTH) and no same-cycle pop SHALL drop the tid and set err_overflow; push with same-cycle pop when full SHALL succeed.
REQ-018 Head timer SHALL reset to 0 whenever the head changes (pop or push into empty) and increment each cycle while FIFO non-empty; idle at 0 when empty.
REQ-019 afu_rsp_valid with afu_rsp_tid == head tid and FIFO non-empty SHALL pop the head and forward tid/data.
REQ-020 afu_rsp_valid with tid != head tid, or while empty, SHALL be dropped and set err_stray.
REQ-021 Timer reaching TIMEOUT_CYCLES-1 with no matching AFU response that cycle SHALL pop the head, emit response {head tid, TIMEOUT_DATA}, and set err_timeout.
REQ-022 Matching AFU response and timer expiry in the same cycle: AFU response SHALL win; err_timeout unchanged.
REQ-023 fiu_rsp_* SHALL be registered: latency exactly 1 cycle from pop cycle; fiu_rsp_valid high 1 cycle per pop; at most one response per cycle.
REQ-024 FSM states EMPTY, WAIT: EMPTY->WAIT on successful push; WAIT->EMPTY on pop with outstanding==1 and no push; otherwise hold.
REQ-025 outstanding SHALL update the cycle after push/pop; simultaneous push+pop leaves it unchanged.
REQ-026 Timer width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits; it SHALL never wrap.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; full/empty distinguished by extra pointer bit.

Reset
REQ-028 While reset_n low at posedge: FIFO empty, state EMPTY, timer 0, outstanding 0, fiu_rsp_valid 0, fiu_rsp_tid 0, fiu_rsp_data 0, all error flags 0.
REQ-029 Reset mid-operation SHALL discard all tracked tids with no responses emitted; inputs during reset ignored.
REQ-030 Error flags SHALL clear only by reset.

Structure
REQ-031 MMIO tid width (9) and MMIO data width (64) SHALL come from the shared CCI-P package; no local redefinition.
REQ-032 Tid FIFO SHALL be sub-module ofs_plat_ccip_mmio_tid_fifo (push/pop/head/full/empty/count); timer, FSM, response register in top.
REQ-033 Simulation-only assertion (translate_off): fiu_rsp_valid never X after reset.

Verification
REQ-034 Push tid 0x005; AFU responds tid 0x005 data 0x1234 after 10 cycles -> fiu_rsp_valid 1 cycle later, tid 0x005, data 0x1234, no errors.
REQ-035 Push tid 0x011, AFU silent -> exactly TIMEOUT_CYCLES cycles after push, pop; next cycle fiu_rsp tid 0x011 data all-ones, err_timeout=1.
REQ-036 Push 64 tids 0..63 then tid 64 without pop -> outstanding=64, err_overflow=1, responses 0..63 returned in order, tid 64 never returned.
REQ-037 AFU response tid 0x007 while head is 0x003 -> no fiu_rsp_valid, err_stray=1, head still 0x003.
REQ-038 Matching AFU response on expiry cycle -> AFU data returned, err_timeout stays 0; push+pop same cycle at full -> outstanding stays 64.
REQ-039 Assert reset_n low with 5 outstanding -> outstanding=0, no response emitted, flags 0 next cycle.
